fifobram_queue: RTL and testbench

Parametrised BRAM-backed FIFO that implements the fifo_source side of fifobram_interface, for use as prefetch and writeback buffers in the PipeArch datapath. It extends the basic FIFO with the following:
- configurable read latency
- configurable almost-full slack, defaulting to the 16-entry prefetch headroom
- a count wide enough to represent completely full
- explicit full flag
- synchronous flush
- sticky overflow/underflow error flags

---
 rtl/fifobram_queue_pkg.sv | 9 +
 rtl/fifobram_queue_sdp_bram.sv | 27 ++
 rtl/fifobram_queue.sv | 94 +++++++++
 tb/tb_fifobram_queue.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fifobram_queue_pkg.sv
// fifobram_queue_pkg: shared FIFO sizing constants and parameter legality check
package fifobram_queue_pkg;
  localparam int FIFO_DEFAULT_LOG2_DEPTH = 5;
  localparam int PREFETCH_SIZE = 16;
  localparam int FIFO_ALMOSTFULL_SLACK = PREFETCH_SIZE;
  function automatic bit fifo_params_ok(int log2_depth, int slack, int lat);
    return slack > 0 && slack < (1 << log2_depth) && (lat == 1 || lat == 2);
  endfunction
endpackage

// File: rtl/fifobram_queue_sdp_bram.sv
// pipearch_sdp_bram: simple dual-port block RAM with registered read port
module pipearch_sdp_bram #(
  parameter int WIDTH = 32,
  parameter int LOG2_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [LOG2_DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [LOG2_DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem [2**LOG2_DEPTH];
  logic [WIDTH-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // write port; storage is never cleared
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  // registered read port holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end
endmodule

// File: rtl/fifobram_queue.sv
// fifobram_queue: BRAM-backed FIFO with latency, flush and sticky error flags
module fifobram_queue
  import fifobram_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2_DEPTH = FIFO_DEFAULT_LOG2_DEPTH,
  parameter int ALMOSTFULL_SLACK = FIFO_ALMOSTFULL_SLACK,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  almostfull,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] AF_C = (LOG2_DEPTH+1)'(DEPTH - ALMOSTFULL_SLACK);
  if (!fifo_params_ok(LOG2_DEPTH, ALMOSTFULL_SLACK, READ_LATENCY)) begin : g_bad_params
    $error("fifobram_queue: illegal ALMOSTFULL_SLACK or READ_LATENCY");
  end
  logic [LOG2_DEPTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LOG2_DEPTH:0]     count_q, count_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic                    wr_ok, rd_ok;
  logic [WIDTH-1:0]        bram_rdata;
  assign empty = count_q == '0;
  assign full = count_q == DEPTH_C;
  assign almostfull = count_q >= AF_C;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  assign rvalid = vld_q[READ_LATENCY-1];
  // acceptance, pointer/count update and sticky flags; clear overrides requests
  always_comb begin
    wr_ok = we && !full && !clear;
    rd_ok = re && !empty && !clear;
    wptr_d = clear ? '0 : wptr_q + LOG2_DEPTH'(wr_ok);
    rptr_d = clear ? '0 : rptr_q + LOG2_DEPTH'(rd_ok);
    count_d = clear ? '0 : count_q + (LOG2_DEPTH+1)'(wr_ok) - (LOG2_DEPTH+1)'(rd_ok);
    ovf_d = !clear && (ovf_q || (we && full));
    unf_d = !clear && (unf_q || (re && empty));
    vld_d = clear ? '0 : READ_LATENCY'({vld_q, rd_ok});
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      vld_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      vld_q <= vld_d;
    end
  end
  pipearch_sdp_bram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_bram (
    .clk(clk),
    .reset(reset),
    .we_i(wr_ok),
    .waddr_i(wptr_q),
    .wdata_i(wdata),
    .re_i(rd_ok),
    .raddr_i(rptr_q),
    .rdata_o(bram_rdata)
  );
  if (READ_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] rdata_q;
    // extra output stage loads only when the BRAM stage holds a valid word
    always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else if (vld_q[0]) rdata_q <= bram_rdata;
    end
    assign rdata = rdata_q;
  end else begin : g_lat1
    assign rdata = bram_rdata;
  end
endmodule

// File: tb/tb_fifobram_queue.sv
// tb_fifobram_queue: directed table-driven checks for fifobram_queue
module tb_fifobram_queue;
  typedef struct {
    logic we, re, clr;
    logic [31:0] wd;
    logic [42:0] exp;
  } vec_t;
  logic clk = 0, reset = 1;
  logic clear1 = 0, we1 = 0, re1 = 0;
  logic [31:0] wdata1 = 0, rdata1;
  logic rvalid1, af1, full1, empty1, ovf1, unf1;
  logic [4:0] count1;
  logic clear2 = 0, we2 = 0, re2 = 0;
  logic [31:0] wdata2 = 0, rdata2;
  logic rvalid2, af2, full2, empty2, ovf2, unf2;
  logic [4:0] count2;
  int errors = 0, checks = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fifobram_queue #(.WIDTH(32), .LOG2_DEPTH(4), .ALMOSTFULL_SLACK(4), .READ_LATENCY(1)) d1 (
    .clk(clk), .reset(reset), .clear(clear1), .we(we1), .wdata(wdata1), .re(re1),
    .rdata(rdata1), .rvalid(rvalid1), .almostfull(af1), .full(full1), .empty(empty1),
    .count(count1), .overflow(ovf1), .underflow(unf1));
  fifobram_queue #(.WIDTH(32), .LOG2_DEPTH(4), .ALMOSTFULL_SLACK(4), .READ_LATENCY(2)) d2 (
    .clk(clk), .reset(reset), .clear(clear2), .we(we2), .wdata(wdata2), .re(re2),
    .rdata(rdata2), .rvalid(rvalid2), .almostfull(af2), .full(full2), .empty(empty2),
    .count(count2), .overflow(ovf2), .underflow(unf2));
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  function automatic vec_t mk(bit we, bit re, bit clr, int wd, int cnt, bit rv, int rd, bit ovf, bit unf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.wd = wd;
    v.exp = {5'(cnt), rv, ovf, unf, cnt == 16, cnt == 0, cnt >= 12, 32'(rd)};
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive1(bit we, bit re, bit clr, logic [31:0] wd);
    we1 = we; re1 = re; clear1 = clr; wdata1 = wd;
  endtask
  initial begin
    int p, popped, occ, budget;
    bit up, ew, er;
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 0, 'h100 + i, i + 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h999, 16, 0, 0, 1, 0));
    for (int j = 0; j < 16; j++) tbl.push_back(mk(0, 1, 0, 0, 15 - j, 1, 'h100 + j, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 'h10F, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h10F, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 0, 'h300 + k, k + 1, 0, 'h10F, 0, 0));
    tbl.push_back(mk(1, 1, 0, 'h308, 8, 1, 'h300, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h300, 0, 0));
    tbl.push_back(mk(1, 1, 0, 'h400, 1, 0, 'h300, 0, 1));
    for (int k = 1; k < 16; k++) tbl.push_back(mk(1, 0, 0, 'h400 + k, k + 1, 0, 'h300, 0, 1));
    tbl.push_back(mk(1, 1, 0, 'h555, 15, 1, 'h400, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h400, 0, 0));
    tick();
    tick();
    reset = 0;
    chk("reset_d1", {count1, rvalid1, ovf1, unf1, full1, empty1, af1, rdata1}, {5'd0, 6'b000010, 32'd0});
    chk("reset_d2", {count2, rvalid2, ovf2, unf2, full2, empty2, af2, rdata2}, {5'd0, 6'b000010, 32'd0});
    foreach (tbl[i]) begin
      drive1(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].wd);
      tick();
      chk($sformatf("vec[%0d]", i), {count1, rvalid1, ovf1, unf1, full1, empty1, af1, rdata1}, tbl[i].exp);
    end
    p = 0; popped = 0; occ = 0; up = 1; budget = 0;
    while (popped < 40 && budget < 400) begin
      ew = up && p < 40;
      er = (!up || p >= 40) && occ > 0;
      drive1(ew, er, 0, 'h200 + p);
      tick();
      budget++;
      occ += int'(ew) - int'(er);
      p += int'(ew);
      chk("wrap_count", count1, occ);
      chk("wrap_rvalid", rvalid1, er);
      if (er) begin
        chk("wrap_rdata", rdata1, 'h200 + popped);
        popped++;
      end
      if (occ >= 7) up = 0;
      if (occ <= 3) up = 1;
    end
    chk("wrap_done", popped, 40);
    drive1(0, 0, 0, 0);
    re2 = 1;
    tick();
    chk("l2_underflow", {rvalid2, unf2, empty2}, 3'b011);
    re2 = 0; we2 = 1; wdata2 = 'hA0;
    tick();
    wdata2 = 'hA1;
    tick();
    we2 = 0; re2 = 1;
    tick();
    chk("l2_t1", {count2, rvalid2}, {5'd1, 1'b0});
    re2 = 0;
    tick();
    chk("l2_t2", {rvalid2, rdata2}, {1'b1, 32'hA0});
    re2 = 1;
    tick();
    chk("l2_rd_count", count2, 0);
    re2 = 0; clear2 = 1;
    tick();
    clear2 = 0;
    chk("l2_clear", {count2, rvalid2, ovf2, unf2, empty2}, {5'd0, 4'b0001});
    tick();
    chk("l2_no_late_rvalid", rvalid2, 0);
    for (int i = 0; i < 17; i++) begin
      drive1(1, 0, 0, 'h600 + i);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive1(0, 1, 0, 0);
      tick();
    end
    chk("rst_pre", {count1, ovf1, rvalid1, rdata1}, {5'd10, 2'b11, 32'h605});
    reset = 1;
    tick();
    reset = 0;
    drive1(0, 0, 0, 0);
    chk("rst_mid", {count1, empty1, ovf1, unf1, rvalid1}, {5'd0, 4'b1000});
    drive1(1, 0, 0, 'hABC);
    tick();
    drive1(0, 1, 0, 0);
    tick();
    drive1(0, 0, 0, 0);
    chk("rst_after", {count1, rvalid1, rdata1}, {5'd0, 1'b1, 32'hABC});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
